// File: rtl/hamming_rx_sequencer.sv
// rtl/hamming_rx_sequencer.sv - Hamming(7,4) receive framer, single-error corrector and output FIFO
module hamming_rx_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic             bit_ready,
  output logic [3:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             err_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic             overflow,
  output logic             abort,
  input  logic             clr_stat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t      state;
  logic [6:0]  cw;
  logic [2:0]  cnt;
  logic        accept;
  logic [2:0]  syn;
  logic [6:0]  fixed;
  logic [3:0]  nibble;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          pop, push_ok, decoding;

  assign accept = bit_valid & bit_ready;

  // cw[i] holds codeword position i+1
  always_comb begin
    syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
           cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
           cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    fixed = cw;
    if (syn != 3'd0)
      fixed[syn - 3'd1] = ~cw[syn - 3'd1];
    nibble = {fixed[2], fixed[4], fixed[5], fixed[6]};
  end

  always_comb begin
    decoding   = (state == DECODE);
    pop        = (count != '0) && data_ready;
    push_ok    = decoding && ((count != DEPTH_C) || pop);
    count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    rd_next    = rd_ptr + AW'(pop);
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cw        <= '0;
      cnt       <= '0;
      bit_ready <= 1'b1;
      err_pulse <= 1'b0;
      frame_cnt <= '0;
      corr_cnt  <= '0;
      overflow  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && sof) begin
            cw[0] <= bit_in;
            cnt   <= 3'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            if (sof) begin
              cw[0] <= bit_in;
              cnt   <= 3'd1;
            end else begin
              cw[cnt] <= bit_in;
              cnt     <= cnt + 3'd1;
              if (cnt == 3'd6) begin
                state     <= DECODE;
                bit_ready <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bit_ready <= 1'b1;
          if (push_ok && syn != 3'd0)
            err_pulse <= 1'b1;
        end
      endcase

      // clear wins over any same-cycle increment or sticky set
      if (clr_stat) begin
        frame_cnt <= '0;
        corr_cnt  <= '0;
        overflow  <= 1'b0;
        abort     <= 1'b0;
      end else begin
        if (push_ok && frame_cnt != CNT_MAX)
          frame_cnt <= frame_cnt + 1'b1;
        if (push_ok && syn != 3'd0 && corr_cnt != CNT_MAX)
          corr_cnt <= corr_cnt + 1'b1;
        if (decoding && !push_ok)
          overflow <= 1'b1;
        if (state == SHIFT && accept && sof)
          abort <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fast) begin
    if (push_ok)
      mem[wr_ptr] <= nibble;
  end

  // data_out tracks the next head so it holds its last value once the FIFO drains
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      count      <= count_next;
      rd_ptr     <= rd_next;
      data_valid <= (count_next != '0);
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (count_next != '0) begin
        if (push_ok && count == (AW+1)'(pop))
          data_out <= nibble;
        else
          data_out <= mem[rd_next];
      end
    end
  end

endmodule
